// File: rtl/lz77_window_decoder.sv
// lz77_window_decoder
//   Byte-serial LZ77 decompressor. Accepts (offset, length, literal) tokens,
//   replays `length` bytes from a DATA_num-deep history window at distance
//   `offset`, then emits the literal. Every emitted byte is written back into
//   the window.
//
// Ports
//   Clk          clock, rising edge
//   Rst          asynchronous active-low reset
//   Clr          synchronous clear of FSM, write pointer, fill and Err
//   Tok_valid    token present
//   Tok_ready    decoder accepts a token this cycle
//   Tok_offset   back-reference distance (0 = no copy)
//   Tok_length   copy length
//   Tok_literal  byte emitted after the copy
//   Dout         decoded byte
//   Dout_valid   Dout holds a valid byte
//   Dout_ready   sink accepts Dout
//   Busy         a token is being expanded
//   Err          sticky bad-reference flag
//
// Build option
//   LZ77_DEC_REFCHK_EN  enables the fill counter and reference checking.
//                       Copies reaching past the valid history set Err and
//                       emit 0x00 bytes. Undefined: Err is tied low.

module lz77_window_decoder #(
  parameter int DATA_width = 8,
  parameter int DATA_num   = 64,
  parameter int ADDR_num   = 6
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Clr,
  input  logic                  Tok_valid,
  output logic                  Tok_ready,
  input  logic [ADDR_num-1:0]   Tok_offset,
  input  logic [ADDR_num-1:0]   Tok_length,
  input  logic [DATA_width-1:0] Tok_literal,
  output logic [DATA_width-1:0] Dout,
  output logic                  Dout_valid,
  input  logic                  Dout_ready,
  output logic                  Busy,
  output logic                  Err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_COPY = 2'd1;
  localparam logic [1:0] ST_LIT  = 2'd2;

  logic [1:0]            state;
  logic                  ready_en;
  logic [DATA_width-1:0] window [DATA_num];
  logic [ADDR_num-1:0]   wptr;
  logic [ADDR_num-1:0]   off_q;
  logic [ADDR_num-1:0]   cnt;
  logic [DATA_width-1:0] lit_q;
  logic                  bad_q;
  logic [ADDR_num-1:0]   rd_addr;
  logic                  copy_tok;
  logic                  ref_bad;
  logic                  accept;
  logic                  fire;

  // Clr outranks every other input: no token is taken and nothing is
  // written to the window in a clear cycle.
  assign copy_tok   = (Tok_length != '0) && (Tok_offset != '0);
  assign Tok_ready  = ready_en && (state == ST_IDLE);
  assign accept     = Tok_valid && Tok_ready && !Clr;
  assign Dout_valid = (state != ST_IDLE);
  assign fire       = Dout_valid && Dout_ready && !Clr;
  assign Busy       = (state != ST_IDLE);
  assign rd_addr    = wptr - off_q;

  always_comb begin
    Dout = '0;
    case (state)
      ST_COPY: Dout = bad_q ? '0 : window[rd_addr];
      ST_LIT:  Dout = lit_q;
      default: Dout = '0;
    endcase
  end

`ifdef LZ77_DEC_REFCHK_EN
  localparam logic [ADDR_num:0] FILL_MAX = (ADDR_num+1)'(DATA_num);

  logic [ADDR_num:0] fill;
  logic              err_q;

  assign ref_bad = copy_tok && ({1'b0, Tok_offset} > fill);
  assign Err     = err_q;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      fill  <= '0;
      err_q <= 1'b0;
    end else if (Clr) begin
      fill  <= '0;
      err_q <= 1'b0;
    end else begin
      if (fire && fill != FILL_MAX) fill <= fill + (ADDR_num+1)'(1);
      if (accept && ref_bad) err_q <= 1'b1;
    end
  end
`else
  assign ref_bad = 1'b0;
  assign Err     = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state    <= ST_IDLE;
      ready_en <= 1'b0;
      wptr     <= '0;
      off_q    <= '0;
      cnt      <= '0;
      lit_q    <= '0;
      bad_q    <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (Clr) begin
        state <= ST_IDLE;
        wptr  <= '0;
      end else begin
        if (accept) begin
          off_q <= Tok_offset;
          cnt   <= Tok_length;
          lit_q <= Tok_literal;
          bad_q <= ref_bad;
          state <= copy_tok ? ST_COPY : ST_LIT;
        end
        if (fire) wptr <= wptr + ADDR_num'(1);
        if (state == ST_COPY && fire) begin
          cnt <= cnt - ADDR_num'(1);
          if (cnt == ADDR_num'(1)) state <= ST_LIT;
        end
        if (state == ST_LIT && fire) state <= ST_IDLE;
      end
    end
  end

  // History is deliberately not reset or cleared.
  always_ff @(posedge Clk) begin
    if (fire) window[wptr] <= Dout;
  end

endmodule
